// File: rtl/input_port_scheduler.sv
// Round-robin scheduler: settles the input-port mux on a pending port, captures one byte, presents it until ack.
// Latency req->valid is SETTLE_CYC+2 edges; without ack the sample is dropped after TIMEOUT cycles (0 = hold forever).
module input_port_scheduler #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] din,
  input  logic       ack,
  output logic [1:0] sel_port,
  output logic       valid,
  output logic [7:0] dout,
  output logic [1:0] port_id,
  output logic       busy,
  output logic [3:0] overflow,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, PRESENT} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] TMO_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
  localparam bit         TMO_EN      = (TIMEOUT != 0);

  state_t     state, state_nxt;
  logic [3:0] pending;
  logic [3:0] clr_mask;
  logic [1:0] last_grant;
  logic [1:0] grant;
  logic       grant_vld;
  logic [3:0] settle_cnt;
  logic [7:0] tmo_cnt;
  logic       settle_done;
  logic       tmo_expire;

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign tmo_expire  = TMO_EN && (tmo_cnt == TMO_LAST);
  assign busy        = (state != IDLE);
  // sel_port carries the grant for the whole service, so it doubles as the granted-port register
  assign clr_mask    = (state == CAPTURE) ? (4'b0001 << sel_port) : 4'b0000;

  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!grant_vld && pending[2'(last_grant + 2'(i))]) begin
        grant     = 2'(last_grant + 2'(i));
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = CAPTURE;
      CAPTURE: state_nxt = PRESENT;
      PRESENT: if (ack || tmo_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= 4'b0000;
      overflow   <= 4'b0000;
      last_grant <= 2'd3;
      sel_port   <= 2'd0;
      valid      <= 1'b0;
      dout       <= 8'h00;
      port_id    <= 2'd0;
      timeout    <= 1'b0;
      settle_cnt <= 4'd0;
      tmo_cnt    <= 8'd0;
    end else begin
      // a new request on the clearing edge re-arms the port instead of counting as lost
      pending  <= (pending & ~clr_mask) | req;
      overflow <= overflow | (req & pending & ~clr_mask);
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            sel_port   <= grant;
            settle_cnt <= 4'd0;
          end
        end
        SETTLE: begin
          if (!settle_done) settle_cnt <= settle_cnt + 4'd1;
        end
        CAPTURE: begin
          dout       <= din;
          port_id    <= sel_port;
          last_grant <= sel_port;
          valid      <= 1'b1;
          tmo_cnt    <= 8'd0;
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
          end else if (tmo_expire) begin
            valid   <= 1'b0;
            timeout <= 1'b1;
          end else if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/input_port_scheduler.md
INPUT_PORT_SCHEDULER -- requirements
Module: input_port_scheduler

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, meaning cycles to hold sel_port before capture (range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max cycles valid waits for ack; 0 = wait forever (range 0..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-port "new data" pulse, bit n = port n.
REQ-006 SHALL have port din  input  8  selected port data from the input-port mux.
REQ-007 SHALL have port ack  input  1  consumer has taken dout.
REQ-008 SHALL have port sel_port  output  2  port select to the input-port mux.
REQ-009 SHALL have port valid  output  1  dout/port_id hold a serviced sample.
REQ-010 SHALL have port dout  output  8  captured data.
REQ-011 SHALL have port port_id  output  2  port that dout came from.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port overflow  output  4  sticky per-port lost-request flags.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse when a sample is dropped.

Function
REQ-015 SHALL keep pending[3:0]; req[n]=1 at an edge sets pending[n].
REQ-016 SHALL clear pending[g] on the edge leaving CAPTURE for granted port g; a simultaneous req[g] keeps it set (set wins).
REQ-017 SHALL set overflow[n] when req[n]=1 while pending[n]=1 and pending[n] is not cleared that edge; overflow clears only on reset.
REQ-018 SHALL implement FSM IDLE, SETTLE, CAPTURE, PRESENT.
REQ-019 IDLE: pending!=0 -> SETTLE at next edge, grant g = first set bit of pending searching round-robin from last_grant+1 mod 4; sel_port<=g; pending=0 -> stay.
REQ-020 SETTLE: sel_port held at g for exactly SETTLE_CYC cycles, then -> CAPTURE.
REQ-021 CAPTURE: one cycle; on exit dout<=din, port_id<=g, last_grant<=g, valid<=1, -> PRESENT.
REQ-022 PRESENT: ack=1 at edge -> valid<=0, IDLE; dout/port_id hold their values until the next capture.
REQ-023 PRESENT with TIMEOUT>0: after TIMEOUT consecutive cycles in PRESENT without ack -> valid<=0, timeout=1 for one cycle, IDLE; ack on the same edge as expiry counts as ack (no timeout pulse).
REQ-024 SHALL ignore ack outside PRESENT.
REQ-025 SHALL produce latency, with SETTLE_CYC=1 in IDLE: req at edge 0 -> sel_port valid after edge 1, valid high after edge 3.
REQ-026 SHALL keep sel_port stable from entry to SETTLE until return to IDLE; in IDLE sel_port holds last_grant.
REQ-027 SHALL not restart arbitration on new req during SETTLE/CAPTURE/PRESENT; requests only accumulate in pending.
REQ-028 SHALL use 4-bit settle counter and 8-bit timeout counter, both reloaded on state entry; no wrap beyond terminal value.

Reset
REQ-029 SHALL on reset=1 asynchronously force: state IDLE, pending 0, overflow 0, last_grant 3 (first grant search starts at port 0), sel_port 0, valid 0, dout 0, port_id 0, busy 0, timeout 0, counters 0.
REQ-030 SHALL on reset mid-operation abandon the in-flight sample with no timeout pulse; the first edge after release behaves as IDLE.

Verification
REQ-031 Single request: req=4'b0100 one cycle, din=8'hA5 while sel_port=2 -> sel_port=2 after edge 1, valid=1, dout=A5, port_id=2 after edge 3; ack -> valid=0 next edge.
REQ-032 Round-robin: req=4'b1111 one cycle, ack each sample immediately -> port_id sequence 0,1,2,3; then req=4'b0011 -> 0,1.
REQ-033 Overflow: req[1] pulsed twice while port 1 still pending -> overflow=4'b0010 stays set; port 1 serviced once.
REQ-034 Timeout: TIMEOUT=15, no ack -> valid high exactly 15 cycles, timeout pulse 1 cycle, busy=0 after; ack on expiry edge -> no pulse.
REQ-035 Set-wins: req[0] on the edge leaving CAPTURE for port 0 -> pending[0] remains 1, port 0 serviced again, overflow[0]=0.
REQ-036 Reset in PRESENT: assert reset asynchronously -> valid, busy, pending, overflow 0 immediately; no timeout pulse.
